ifu_ctrl: RTL and testbench
===========================

// Module: ifu_ctrl
// PURPOSE
//   Instruction-fetch controller for the 5-stage MIPS pipeline.
//   - Owns the F-stage PC and drives the word address into the combinational instruction memory.
//   - Selects the next PC from sequential, branch, j/jal and jr redirects, honouring the delay slot.
//   - Applies stall, flush and halt, and holds the IF/ID pipeline register feeding the decode stage.
// PARAMETERS
//   PC_BASE   32'h0000_3000  reset PC; byte address of instruction-memory word 0
//   IM_AW     10             instruction-memory word-address width (depth = 2**IM_AW words)
//   NOP_INSTR 32'h0000_0000  instruction injected as a bubble (sll $0,$0,0)
// PORTS
//   clk            in   1      system clock, all state updates on posedge
//   reset          in   1      synchronous, active-high
//   stall          in   1      hazard-unit stall: hold PC and IF/ID
//   flush          in   1      load bubble into IF/ID (exception/eret path)
//   halt_req       in   1      stop fetching after the current cycle
//   br_taken       in   1      D-stage branch resolved taken
//   br_target      in   32     branch target byte address
//   j_en           in   1      D-stage j/jal
//   j_target       in   32     jump target byte address
//   jr_en          in   1      D-stage jr/jalr
//   jr_target      in   32     forwarded rs value
//   im_addr        out  IM_AW  word address to instruction memory = (pc_f-PC_BASE)>>2
//   im_dout        in   32     instruction word returned combinationally, same cycle
//   pc_f           out  32     current F-stage PC
//   instr_d        out  32     IF/ID instruction
//   pc_d           out  32     IF/ID PC
//   pc8_d          out  32     IF/ID PC+8 (link value)
//   fault_d        out  1      IF/ID entry carries a fetch fault
//   halted         out  1      FSM in HALT
//   fetch_cnt      out  32     count of instructions accepted into IF/ID
// BEHAVIOUR
//   Reset (synchronous):
//     - pc_f=PC_BASE; instr_d=NOP_INSTR; pc_d=PC_BASE; pc8_d=PC_BASE+8.
//     - fault_d=0; fetch_cnt=0; state=BOOT; halted=0.
//   FSM states:
//     - BOOT: one cycle. IF/ID keeps the bubble, PC holds. Always goes to RUN.
//     - RUN: normal fetch. Goes to HALT on halt_req, or when a fault entry is accepted.
//     - HALT: PC, IF/ID and counter frozen; halted=1. Left only by reset.
//   Fetch fault: fault_f=1 when any of these holds:
//     - pc_f[1:0]!=0
//     - pc_f<PC_BASE
//     - pc_f>=PC_BASE+4*2**IM_AW
//   RUN cycle priority:
//     - 1. stall=1:
//         - PC holds.
//         - IF/ID holds unless flush=1, which loads the bubble.
//         - Redirect inputs are ignored this cycle; the D stage re-presents them.
//     - 2. Otherwise, next PC (first match wins):
//         - jr_en -> jr_target
//         - j_en -> j_target
//         - br_taken -> br_target
//         - else pc_f+4
//       Arithmetic is 32-bit modulo.
//     - 3. IF/ID update:
//         - flush=1 -> bubble, fault_d=0.
//         - fault_f=1 -> bubble, fault_d=1, FSM to HALT, PC holds.
//         - else instr_d=im_dout, pc_d=pc_f, pc8_d=pc_f+8, fault_d=0, fetch_cnt+1.
//     - Delay slot: a redirect does NOT flush the slot already being fetched; it enters IF/ID normally.
//     - halt_req in RUN without stall: the current fetch completes, then HALT.
//   Latency: instruction at pc_f appears on instr_d one cycle later. im_addr tracks pc_f combinationally.
//   Reset mid-operation overrides every other input. Stall in BOOT/HALT has no effect.
// STRUCTURE
//   Shared package/header (mips_defs):
//     - PC_BASE and NOP_INSTR.
//     - FSM state encodings BOOT=2'd0, RUN=2'd1, HALT=2'd2.
//   One natural sub-module, npc_sel: the combinational next-PC priority mux.
//   PC register, IF/ID register, FSM and counter stay in ifu_ctrl.
// TESTING
//   1. Reset, then 4 cycles with no redirects:
//      - pc_f goes 3000,3000(BOOT),3004,3008.
//      - instr_d holds the words at 0x3000 and 0x3004 in order.
//      - fetch_cnt=2.
//   2. br_taken=1, br_target=0x3040 while pc_f=0x3008:
//      - Next cycle pc_f=0x3040 and instr_d=word at 0x3008 (delay slot kept).
//   3. stall=1 for 3 cycles together with j_en=1:
//      - pc_f and instr_d unchanged, fetch_cnt unchanged.
//      - After stall drops with j_en still high, pc_f=j_target.
//   4. Same cycle stall=1, flush=1:
//      - instr_d=0, pc_f held.
//   5. Same cycle jr_en=1, j_en=1, br_taken=1:
//      - pc_f=jr_target.
//   6. jr_target=0x3002:
//      - Next cycle fault_d=1, instr_d=0, halted=1.
//      - pc_f frozen at 0x3002 until reset; reset returns pc_f to 0x3000.

Source files
------------

// File: rtl/ifu_ctrl_pkg.sv
// Shared fetch-stage constants, FSM encoding and the IF/ID payload type.
package ifu_ctrl_pkg;

    localparam logic [31:0] DEF_PC_BASE   = 32'h0000_3000;
    localparam int unsigned DEF_IM_AW     = 10;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        fault;
    } ifid_t;

endpackage

// File: rtl/ifu_ctrl_if.sv
// Fetch-controller bundle: D-stage controls/redirects, instruction memory and IF/ID outputs.
interface ifu_ctrl_if #(
    parameter int unsigned IM_AW = 10
);
    logic             stall;
    logic             flush;
    logic             halt_req;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             j_en;
    logic [31:0]      j_target;
    logic             jr_en;
    logic [31:0]      jr_target;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_dout;
    logic [31:0]      pc_f;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      pc8_d;
    logic             fault_d;
    logic             halted;
    logic [31:0]      fetch_cnt;

    // Fetch controller side
    modport master (
        input  stall, flush, halt_req,
        input  br_taken, br_target, j_en, j_target, jr_en, jr_target,
        input  im_dout,
        output im_addr, pc_f, instr_d, pc_d, pc8_d, fault_d, halted, fetch_cnt
    );

    // Pipeline / memory side
    modport slave (
        output stall, flush, halt_req,
        output br_taken, br_target, j_en, j_target, jr_en, jr_target,
        output im_dout,
        input  im_addr, pc_f, instr_d, pc_d, pc8_d, fault_d, halted, fetch_cnt
    );

endinterface

// File: rtl/ifu_ctrl_npc_sel.sv
// Next-PC priority mux: jr over j over taken branch over sequential.
module ifu_ctrl_npc_sel (
    input  logic [31:0] pc,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        j_en,
    input  logic [31:0] j_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] npc_c
);

    // First matching redirect wins; sequential wraps modulo 2^32
    always_comb begin
        npc_c = pc + 32'd4;
        if (jr_en) begin
            npc_c = jr_target;
        end else if (j_en) begin
            npc_c = j_target;
        end else if (br_taken) begin
            npc_c = br_target;
        end
    end

endmodule

// File: rtl/ifu_ctrl.sv
// Instruction-fetch controller: F-stage PC, next-PC selection, IF/ID register and fetch FSM.
module ifu_ctrl
    import ifu_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_BASE   = DEF_PC_BASE,
    parameter int unsigned IM_AW     = DEF_IM_AW,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    ifu_ctrl_if.master  bus
);

    // One past the last byte covered by instruction memory (33 bits so it cannot wrap)
    localparam logic [32:0] IM_END = {1'b0, PC_BASE} + (33'd1 << (IM_AW + 2));

    ifu_state_e  state_q;
    logic [31:0] pc_q;
    ifid_t       ifid_q;
    logic [31:0] cnt_q;
    logic        halted_q;

    logic [31:0] npc_c;
    logic [31:0] pc_off_c;
    logic        fault_f_c;

    ifu_ctrl_npc_sel u_npc_sel (
        .pc        (pc_q),
        .jr_en     (bus.jr_en),
        .jr_target (bus.jr_target),
        .j_en      (bus.j_en),
        .j_target  (bus.j_target),
        .br_taken  (bus.br_taken),
        .br_target (bus.br_target),
        .npc_c     (npc_c)
    );

    // Word address into instruction memory and fetch-fault detection for the current PC
    always_comb begin
        pc_off_c  = pc_q - PC_BASE;
        fault_f_c = (pc_q[1:0] != 2'b00) || (pc_q < PC_BASE) || ({1'b0, pc_q} >= IM_END);
    end

    assign bus.im_addr   = IM_AW'(pc_off_c >> 2);
    assign bus.pc_f      = pc_q;
    assign bus.instr_d   = ifid_q.instr;
    assign bus.pc_d      = ifid_q.pc;
    assign bus.pc8_d     = ifid_q.pc8;
    assign bus.fault_d   = ifid_q.fault;
    assign bus.halted    = halted_q;
    assign bus.fetch_cnt = cnt_q;

    // Fetch FSM with PC, IF/ID and accepted-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            pc_q     <= PC_BASE;
            ifid_q   <= '{instr: NOP_INSTR, pc: PC_BASE, pc8: PC_BASE + 32'd8, fault: 1'b0};
            cnt_q    <= 32'd0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.halt_req) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                    if (bus.stall) begin
                        // PC frozen; redirects are re-presented once the stall clears
                        if (bus.flush) begin
                            ifid_q.instr <= NOP_INSTR;
                            ifid_q.fault <= 1'b0;
                        end
                    end else if (bus.flush) begin
                        pc_q         <= npc_c;
                        ifid_q.instr <= NOP_INSTR;
                        ifid_q.fault <= 1'b0;
                    end else if (fault_f_c) begin
                        // Faulting PC is recorded in pc_d so the handler can see it
                        ifid_q   <= '{instr: NOP_INSTR, pc: pc_q, pc8: pc_q + 32'd8, fault: 1'b1};
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q   <= npc_c;
                        ifid_q <= '{instr: bus.im_dout, pc: pc_q, pc8: pc_q + 32'd8, fault: 1'b0};
                        cnt_q  <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    // HALT (and any unused encoding): everything frozen until reset
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_ctrl.sv
// Self-checking bench for ifu_ctrl: directed scenarios plus randomized redirects/stalls.
module tb_ifu_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int unsigned WORDS = 1024;

    logic clk;
    logic reset;

    ifu_ctrl_if #(.IM_AW(10)) bus ();

    ifu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [WORDS];
    assign bus.im_dout = mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model state: 0 = boot, 1 = run, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pcd, m_pc8, m_cnt;
    logic        m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[(pc - BASE) >> 2];
    endfunction

    function automatic bit is_bad(input logic [31:0] pc);
        longint unsigned p;
        p = longint'(pc);
        return (pc % 4 != 0) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * WORDS);
    endfunction

    // Advance the reference model by one clock using the inputs that were presented
    task automatic model_step();
        logic [31:0] nxt;
        if (reset) begin
            m_mode = 0; m_pc = BASE; m_instr = 0; m_pcd = BASE; m_pc8 = BASE + 8;
            m_fault = 0; m_cnt = 0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
            return;
        end
        if (m_mode != 1) return;
        if (bus.jr_en)         nxt = bus.jr_target;
        else if (bus.j_en)     nxt = bus.j_target;
        else if (bus.br_taken) nxt = bus.br_target;
        else                   nxt = m_pc + 4;
        if (bus.halt_req) m_mode = 2;
        if (bus.stall) begin
            if (bus.flush) begin m_instr = 0; m_fault = 0; end
        end else if (bus.flush) begin
            m_pc = nxt; m_instr = 0; m_fault = 0;
        end else if (is_bad(m_pc)) begin
            m_instr = 0; m_fault = 1; m_pcd = m_pc; m_pc8 = m_pc + 8; m_mode = 2;
        end else begin
            m_instr = word_at(m_pc); m_pcd = m_pc; m_pc8 = m_pc + 8; m_cnt = m_cnt + 1;
            m_pc = nxt;
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_f",      bus.pc_f,      m_pc);
            chk("im_addr",   32'(bus.im_addr), ((m_pc - BASE) >> 2) & 32'(WORDS - 1));
            chk("instr_d",   bus.instr_d,   m_instr);
            chk("pc_d",      bus.pc_d,      m_pcd);
            chk("pc8_d",     bus.pc8_d,     m_pc8);
            chk("fault_d",   32'(bus.fault_d), 32'(m_fault));
            chk("halted",    32'(bus.halted),  32'(m_mode == 2));
            chk("fetch_cnt", bus.fetch_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.stall = 0; bus.flush = 0; bus.halt_req = 0;
        bus.br_taken = 0; bus.br_target = 0;
        bus.j_en = 0; bus.j_target = 0;
        bus.jr_en = 0; bus.jr_target = 0;
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 90)      return BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        else if (r < 95) return BASE + 32'($urandom_range(0, 4 * WORDS - 1));
        else             return 32'($urandom);
    endfunction

    int halt_cycles;

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'($urandom);
        clr_in();
        reset = 1;
        tick();
        tick();
        chk_en = 1;
        reset  = 0;

        // Reset state, then BOOT holds the PC
        chk("rst_pc_f", bus.pc_f, 32'h3000);
        chk("rst_pc8_d", bus.pc8_d, 32'h3008);
        tick();
        chk("boot_pc_f", bus.pc_f, 32'h3000);
        chk("boot_instr", bus.instr_d, 32'h0);
        tick();
        chk("seq1_pc_f", bus.pc_f, 32'h3004);
        chk("seq1_instr", bus.instr_d, mem[0]);
        tick();
        chk("seq2_pc_f", bus.pc_f, 32'h3008);
        chk("seq2_instr", bus.instr_d, mem[1]);
        chk("seq2_cnt", bus.fetch_cnt, 32'd2);

        // Taken branch keeps the delay slot
        bus.br_taken = 1; bus.br_target = 32'h3040;
        tick();
        clr_in();
        chk("br_pc_f", bus.pc_f, 32'h3040);
        chk("br_slot", bus.instr_d, mem[2]);

        // Stall with a pending jump, then release
        bus.stall = 1; bus.j_en = 1; bus.j_target = 32'h3100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc_f", bus.pc_f, 32'h3040);
            chk("stall_instr", bus.instr_d, mem[2]);
            chk("stall_cnt", bus.fetch_cnt, 32'd3);
        end
        bus.stall = 0;
        tick();
        clr_in();
        chk("jump_pc_f", bus.pc_f, 32'h3100);
        chk("jump_instr", bus.instr_d, mem[16]);

        // Stall plus flush: bubble, PC held
        bus.stall = 1; bus.flush = 1;
        tick();
        clr_in();
        chk("sflush_instr", bus.instr_d, 32'h0);
        chk("sflush_pc_f", bus.pc_f, 32'h3100);

        // All redirects together: jr wins
        bus.jr_en = 1; bus.jr_target = 32'h3200;
        bus.j_en = 1; bus.j_target = 32'h3300;
        bus.br_taken = 1; bus.br_target = 32'h3400;
        tick();
        clr_in();
        chk("prio_pc_f", bus.pc_f, 32'h3200);
        chk("prio_instr", bus.instr_d, mem[64]);

        // Misaligned jr target faults and halts
        bus.jr_en = 1; bus.jr_target = 32'h3002;
        tick();
        clr_in();
        chk("mis_pc_f", bus.pc_f, 32'h3002);
        tick();
        chk("flt_fault", 32'(bus.fault_d), 32'd1);
        chk("flt_instr", bus.instr_d, 32'h0);
        chk("flt_halted", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.stall = 1'($urandom); bus.jr_en = 1; bus.jr_target = 32'h3000;
            tick();
            chk("halt_pc_f", bus.pc_f, 32'h3002);
        end
        clr_in();
        reset = 1;
        tick();
        reset = 0;
        chk("rerst_pc_f", bus.pc_f, 32'h3000);
        chk("rerst_halted", 32'(bus.halted), 32'd0);

        // Randomized traffic against the model
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.stall     = ($urandom_range(0, 4) == 0);
            bus.flush     = ($urandom_range(0, 11) == 0);
            bus.halt_req  = ($urandom_range(0, 149) == 0);
            bus.br_taken  = ($urandom_range(0, 5) == 0);
            bus.br_target = rand_target();
            bus.j_en      = ($urandom_range(0, 9) == 0);
            bus.j_target  = rand_target();
            bus.jr_en     = ($urandom_range(0, 11) == 0);
            bus.jr_target = rand_target();
            halt_cycles   = (m_mode == 2) ? halt_cycles + 1 : 0;
            reset         = (halt_cycles > 4) || ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;
        clr_in();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
